// File: rtl/sips4_loader_if.sv
// Serial input plus instruction-memory write port and status of the SIPS4 loader.
// master = the loader, slave = the core/memory side that feeds the line and consumes writes.
interface sips4_loader_if;
  logic        uart_rx;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_run;
  logic        busy;
  logic        err;

  modport master (
    input  uart_rx,
    output imem_we, imem_addr, imem_wdata, cpu_run, busy, err
  );

  modport slave (
    output uart_rx,
    input  imem_we, imem_addr, imem_wdata, cpu_run, busy, err
  );
endinterface

// File: rtl/sips4_loader.sv
// SIPS4 program loader: 8N1 receiver feeding a frame FSM (A5, 16 words hi/lo, 8-bit sum)
// that writes instruction memory and only releases cpu_run on a verified image.
//
// rx state    | meaning
// RX_IDLE     | line idle, waiting for a synchronised falling edge
// RX_START    | half a bit after the edge, confirm the start bit is still low
// RX_DATA     | sample 8 data bits LSB first at bit centre
// RX_STOP     | sample stop bit; high = byte, low = framing error
//
// ld state    | meaning
// LD_WAIT_HDR | no valid image, core held; waiting for 0xA5
// LD_RECV_HI  | expecting high byte of word[idx]
// LD_RECV_LO  | expecting low byte of word[idx]; writes memory
// LD_RECV_SUM | expecting checksum of the 32 data bytes
// LD_RUN      | verified image, core running; 0xA5 restarts loading
module sips4_loader #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  sips4_loader_if.master bus
);
  localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int TO_CLK = TIMEOUT_BITS * DIV;
  localparam int BCW    = $clog2(DIV + 1);
  localparam int TCW    = $clog2(TO_CLK + 1);

  localparam logic [BCW-1:0] HALF_M1 = BCW'(DIV / 2 - 1);
  localparam logic [BCW-1:0] DIV_M1  = BCW'(DIV - 1);
  localparam logic [TCW-1:0] TO_M1   = TCW'(TO_CLK - 1);
  localparam logic [7:0]     HDR     = 8'hA5;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] LD_WAIT_HDR = 3'd0;
  localparam logic [2:0] LD_RECV_HI  = 3'd1;
  localparam logic [2:0] LD_RECV_LO  = 3'd2;
  localparam logic [2:0] LD_RECV_SUM = 3'd3;
  localparam logic [2:0] LD_RUN      = 3'd4;

  // Two-flop synchroniser; the third flop only provides the previous value for edge detection.
  logic rx_s1_q, rx_s2_q, rx_s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= bus.uart_rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  logic [1:0]     rx_state_q, rx_state_d;
  logic [BCW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [7:0]     rx_shift_q, rx_shift_d;
  logic           start_edge;
  logic           byte_valid;
  logic           frame_err;
  logic [7:0]     rx_byte;

  assign start_edge = (rx_state_q == RX_IDLE) && rx_s3_q && !rx_s2_q;
  assign rx_byte    = rx_shift_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (start_edge) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_M1;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_s2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = DIV_M1;
            rx_bit_d   = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - BCW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = DIV_M1;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - BCW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          byte_valid = rx_s2_q;
          frame_err  = !rx_s2_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - BCW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  logic [2:0]     ld_state_q, ld_state_d;
  logic [3:0]     idx_q, idx_d;
  logic [7:0]     sum_q, sum_d;
  logic [7:0]     hi_q, hi_d;
  logic           we_q, we_d;
  logic [3:0]     addr_q, addr_d;
  logic [15:0]    wdata_q, wdata_d;
  logic           run_q, run_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout;

  // Gap timer is rearmed by every accepted byte and every start edge while a frame is open.
  assign timeout = busy_q && (to_cnt_q == '0) && !start_edge;

  always_comb begin
    ld_state_d = ld_state_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    hi_d       = hi_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    run_d      = run_q;
    busy_d     = busy_q;
    err_d      = err_q;
    to_cnt_d   = to_cnt_q;

    if (busy_q && (to_cnt_q != '0)) to_cnt_d = to_cnt_q - TCW'(1);
    if (busy_q && start_edge) to_cnt_d = TO_M1;

    if (byte_valid) begin
      case (ld_state_q)
        LD_WAIT_HDR, LD_RUN: begin
          if (rx_byte == HDR) begin
            ld_state_d = LD_RECV_HI;
            busy_d     = 1'b1;
            err_d      = 1'b0;
            run_d      = 1'b0;
            idx_d      = 4'd0;
            sum_d      = 8'd0;
            to_cnt_d   = TO_M1;
          end
        end
        LD_RECV_HI: begin
          hi_d       = rx_byte;
          sum_d      = sum_q + rx_byte;
          ld_state_d = LD_RECV_LO;
          to_cnt_d   = TO_M1;
        end
        LD_RECV_LO: begin
          wdata_d  = {hi_q, rx_byte};
          addr_d   = idx_q;
          we_d     = 1'b1;
          sum_d    = sum_q + rx_byte;
          to_cnt_d = TO_M1;
          if (idx_q == 4'd15) begin
            ld_state_d = LD_RECV_SUM;
          end else begin
            idx_d      = idx_q + 4'd1;
            ld_state_d = LD_RECV_HI;
          end
        end
        LD_RECV_SUM: begin
          busy_d = 1'b0;
          if (sum_q == rx_byte) begin
            ld_state_d = LD_RUN;
            run_d      = 1'b1;
          end else begin
            ld_state_d = LD_WAIT_HDR;
            err_d      = 1'b1;
          end
        end
        default: begin
          ld_state_d = LD_WAIT_HDR;
          busy_d     = 1'b0;
          run_d      = 1'b0;
        end
      endcase
    end else if (busy_q && (frame_err || timeout)) begin
      ld_state_d = LD_WAIT_HDR;
      busy_d     = 1'b0;
      err_d      = 1'b1;
      run_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state_q <= LD_WAIT_HDR;
      idx_q      <= '0;
      sum_q      <= '0;
      hi_q       <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      ld_state_q <= ld_state_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      hi_q       <= hi_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_run    = run_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_sips4_loader.sv
// Bench for sips4_loader: byte-level frame model compared every cycle, plus literal timing checks.
module tb_sips4_loader;
  localparam int DIV    = 16;
  // Start drive -> stop-bit centre (9.5*DIV) + 2 sync flops + 1 output register.
  localparam int LAT    = 155;
  localparam int TO_CLK = 20 * DIV;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sips4_loader_if bus();

  sips4_loader #(.CLK_HZ(1_600_000), .BAUD(100_000), .TIMEOUT_BITS(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: pending byte events, frame contents, expected outputs.
  int         q_due[$];
  logic [7:0] q_byte[$];
  logic       q_ok[$];
  bit         m_in_frame;
  int         m_pos;
  logic [7:0] m_bytes[32];
  int         m_deadline;
  logic       e_we, e_run, e_busy, e_err;
  logic [3:0] e_addr;
  logic [15:0] e_wdata;
  int         we_seen;

  task automatic model_reset();
    q_due.delete(); q_byte.delete(); q_ok.delete();
    m_in_frame = 0; m_pos = 0; m_deadline = 0;
    e_we = 0; e_run = 0; e_busy = 0; e_err = 0; e_addr = 0; e_wdata = 0;
  endtask

  task automatic model_abort();
    m_in_frame = 0; m_deadline = 0;
    e_busy = 0; e_err = 1; e_run = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic ok);
    logic [7:0] s;
    if (!ok) begin
      if (m_in_frame) model_abort();
    end else if (!m_in_frame) begin
      if (b == 8'hA5) begin
        m_in_frame = 1; m_pos = 0; m_deadline = cyc + TO_CLK;
        e_busy = 1; e_err = 0; e_run = 0;
      end
    end else if (m_pos < 32) begin
      m_bytes[m_pos] = b;
      if (m_pos % 2 == 1) begin
        e_we = 1; e_addr = 4'(m_pos / 2); e_wdata = {m_bytes[m_pos-1], b};
      end
      m_pos++;
      m_deadline = cyc + TO_CLK;
    end else begin
      s = 8'd0;
      for (int i = 0; i < 32; i++) s = s + m_bytes[i];
      m_in_frame = 0; m_deadline = 0; e_busy = 0;
      if (s == b) e_run = 1;
      else e_err = 1;
    end
  endtask

  always @(negedge clk) begin
    e_we = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      while (q_due.size() > 0 && q_due[0] <= cyc) begin
        model_byte(q_byte.pop_front(), q_ok.pop_front());
        void'(q_due.pop_front());
      end
      if (m_in_frame && m_deadline != 0 && cyc == m_deadline) model_abort();
    end
    if (bus.imem_we === 1'b1) we_seen++;
    check("imem_we", bus.imem_we, e_we);
    check("imem_addr", bus.imem_addr, e_addr);
    check("imem_wdata", bus.imem_wdata, e_wdata);
    check("cpu_run", bus.cpu_run, e_run);
    check("busy", bus.busy, e_busy);
    check("err", bus.err, e_err);
  end

  // All stimulus tasks are entered #1 after a rising edge and return the same way.
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    if (m_deadline != 0 && cyc + 3 < m_deadline) m_deadline = 0;
    q_due.push_back(cyc + LAT); q_byte.push_back(b); q_ok.push_back(stop_bit);
    bus.uart_rx = 1'b0;
    repeat (DIV) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      repeat (DIV) @(posedge clk); #1;
    end
    bus.uart_rx = stop_bit;
    repeat (DIV) @(posedge clk); #1;
    bus.uart_rx = 1'b1;
  endtask

  logic p_run_pre, p_run_post, p_busy_post, p_err_post;

  task automatic send_probe(input logic [7:0] b);
    int k;
    k = cyc;
    fork
      send_byte(b, 1'b1);
      begin
        wait_cyc(k + LAT - 1);
        p_run_pre = bus.cpu_run;
        wait_cyc(k + LAT);
        p_run_post = bus.cpu_run; p_busy_post = bus.busy; p_err_post = bus.err;
      end
    join
  endtask

  task automatic send_frame(input logic [7:0] csum);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h11, 1'b1);
      send_byte(8'(i), 1'b1);
    end
    send_probe(csum);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    bus.uart_rx = 1'b1;
    // 1: reset with the line toggling
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      bus.uart_rx = i[0];
    end
    check("rst_run", bus.cpu_run, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    check("rst_we", bus.imem_we, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_wdata", bus.imem_wdata, 0);
    bus.uart_rx = 1'b1;
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;

    // 2: valid frame
    we_seen = 0;
    send_frame(8'h88);
    check("v_run_pre", p_run_pre, 0);
    check("v_run_post", p_run_post, 1);
    check("v_busy", p_busy_post, 0);
    check("v_err", p_err_post, 0);
    check("v_we_count", we_seen, 16);
    check("v_last_word", bus.imem_wdata, 16'h110F);

    // 3: bad checksum, then good frame
    we_seen = 0;
    send_frame(8'h89);
    check("bc_run", p_run_post, 0);
    check("bc_err", p_err_post, 1);
    check("bc_busy", p_busy_post, 0);
    check("bc_we_count", we_seen, 16);
    send_frame(8'h88);
    check("bc2_run", p_run_post, 1);
    check("bc2_err", p_err_post, 0);

    // 4: glitch, then framing error inside a frame
    bus.uart_rx = 1'b0;
    repeat (5) @(posedge clk); #1;
    bus.uart_rx = 1'b1;
    repeat (40) @(posedge clk); #1;
    check("gl_run", bus.cpu_run, 1);
    check("gl_busy", bus.busy, 0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h3C, 1'b0);
    check("fe_err", bus.err, 1);
    check("fe_busy", bus.busy, 0);
    check("fe_run", bus.cpu_run, 0);
    repeat (20) @(posedge clk); #1;
    send_byte(8'h11, 1'b1);
    check("fe_idle_busy", bus.busy, 0);

    // 5: inter-byte timeout
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    k = cyc;
    send_byte(8'h22, 1'b1);
    wait_cyc(k + LAT + TO_CLK - 1);
    check("to_busy_pre", bus.busy, 1);
    check("to_err_pre", bus.err, 0);
    wait_cyc(k + LAT + TO_CLK);
    check("to_busy_post", bus.busy, 0);
    check("to_err_post", bus.err, 1);
    repeat (4) @(posedge clk); #1;
    send_frame(8'h88);
    check("to_reload_run", p_run_post, 1);
    check("to_reload_err", p_err_post, 0);

    // 6: reload from RUN, reset mid-byte, reload after reset
    send_probe(8'hA5);
    check("rl_run_pre", p_run_pre, 1);
    check("rl_run_post", p_run_post, 0);
    check("rl_busy", p_busy_post, 1);
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h11, 1'b1);
      send_byte(8'(i), 1'b1);
    end
    bus.uart_rx = 1'b0;
    repeat (40) @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("mr_run", bus.cpu_run, 0);
    check("mr_busy", bus.busy, 0);
    check("mr_err", bus.err, 0);
    check("mr_we", bus.imem_we, 0);
    check("mr_addr", bus.imem_addr, 0);
    check("mr_wdata", bus.imem_wdata, 0);
    bus.uart_rx = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    send_frame(8'h88);
    check("ar_run", p_run_post, 1);
    check("ar_busy", p_busy_post, 0);
    check("ar_err", p_err_post, 0);

    repeat (4) @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
